// File: rtl/switch_toggle_ctrl.sv
// switch_toggle_ctrl: button synchroniser and debouncer, press-to-pulse converter, and
// auto-blink pulse generator that feeds the LED toggle FSM. It also tracks the LED state
// the FSM will hold and counts the pulses it has issued.
module switch_toggle_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BLINK_PERIOD    = 32,
    parameter int unsigned PCNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_raw,
    input  logic              enable,
    input  logic              mode_sel,
    output logic              btn_clean,
    output logic              toggle_pulse,
    output logic              led_shadow,
    output logic [1:0]        state,
    output logic [PCNT_W-1:0] pulse_count
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StManual = 2'b01,
        StBlink  = 2'b10
    } state_e;

    logic              s1_q, s2_q;
    logic              btn_clean_q, btn_clean_d;
    logic              btn_clean_dly_q;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              toggle_pulse_q, toggle_pulse_d;
    logic              led_shadow_q, led_shadow_d;
    logic [PCNT_W-1:0] pulse_count_q, pulse_count_d;
    state_e            state_q, state_d;
    logic              rise;

    // Debouncer: btn_clean follows s2 only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        btn_clean_d = btn_clean_q;
        dcnt_d      = '0;
        if (s2_q != btn_clean_q) begin
            if (dcnt_q == DCNT_LAST) begin
                btn_clean_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    assign rise = btn_clean_q & ~btn_clean_dly_q;

    // Controller next state: enable dominates, then mode_sel picks manual or blink.
    always_comb begin
        state_d = StIdle;
        if (enable) begin
            state_d = mode_sel ? StBlink : StManual;
        end
    end

    // Pulse generation is keyed on the next state, so a rise on entry to MANUAL is honoured
    // and one on exit is dropped; blink counting restarts from zero on every entry.
    always_comb begin
        bcnt_d         = '0;
        toggle_pulse_d = 1'b0;
        unique case (state_d)
            StIdle: begin
                toggle_pulse_d = 1'b0;
            end
            StManual: begin
                toggle_pulse_d = rise;
            end
            StBlink: begin
                if (state_q == StBlink) begin
                    if (bcnt_q == BCNT_LAST) begin
                        toggle_pulse_d = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            default: begin
                toggle_pulse_d = 1'b0;
            end
        endcase
        // A blink pulse followed by a press right after switching to MANUAL must not
        // produce back-to-back requests to the LED FSM.
        if (toggle_pulse_q) begin
            toggle_pulse_d = 1'b0;
        end
    end

    // Bookkeeping updates on the same edge that raises toggle_pulse.
    always_comb begin
        led_shadow_d  = led_shadow_q;
        pulse_count_d = pulse_count_q;
        if (toggle_pulse_d) begin
            led_shadow_d  = ~led_shadow_q;
            pulse_count_d = pulse_count_q + PCNT_W'(1);
        end
    end

    // All state registers; asynchronous reset clears everything without emitting a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q            <= 1'b0;
            s2_q            <= 1'b0;
            btn_clean_q     <= 1'b0;
            btn_clean_dly_q <= 1'b0;
            dcnt_q          <= '0;
            bcnt_q          <= '0;
            toggle_pulse_q  <= 1'b0;
            led_shadow_q    <= 1'b0;
            pulse_count_q   <= '0;
            state_q         <= StIdle;
        end else begin
            s1_q            <= btn_raw;
            s2_q            <= s1_q;
            btn_clean_q     <= btn_clean_d;
            btn_clean_dly_q <= btn_clean_q;
            dcnt_q          <= dcnt_d;
            bcnt_q          <= bcnt_d;
            toggle_pulse_q  <= toggle_pulse_d;
            led_shadow_q    <= led_shadow_d;
            pulse_count_q   <= pulse_count_d;
            state_q         <= state_d;
        end
    end

    assign btn_clean    = btn_clean_q;
    assign toggle_pulse = toggle_pulse_q;
    assign led_shadow   = led_shadow_q;
    assign state        = state_q;
    assign pulse_count  = pulse_count_q;

endmodule

// File: tb/tb_switch_toggle_ctrl.sv
// Directed testbench for switch_toggle_ctrl with default parameters (16 / 32 / 8).
module tb_switch_toggle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic       enable;
    logic       mode_sel;
    logic       btn_clean;
    logic       toggle_pulse;
    logic       led_shadow;
    logic [1:0] state;
    logic [7:0] pulse_count;

    int passed = 0;
    int total  = 0;
    int cyc;
    int win_pulses;
    int first_pc;
    int last_pc;
    logic prev_tp = 1'b0;
    logic consec  = 1'b0;
    logic bad;

    switch_toggle_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .BLINK_PERIOD   (32),
        .PCNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .enable      (enable),
        .mode_sel    (mode_sel),
        .btn_clean   (btn_clean),
        .toggle_pulse(toggle_pulse),
        .led_shadow  (led_shadow),
        .state       (state),
        .pulse_count (pulse_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (toggle_pulse) begin
            win_pulses++;
            if (first_pc < 0) first_pc = cyc;
            last_pc = cyc;
            if (prev_tp) consec = 1'b1;
        end
        prev_tp = toggle_pulse;
    endtask

    task automatic win_reset();
        cyc        = 0;
        win_pulses = 0;
        first_pc   = -1;
        last_pc    = -1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        mode_sel = 1'b0;
        btn_raw  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_raw  = 1'b0;
        enable   = 1'b0;
        mode_sel = 1'b0;
        win_reset();
        do_reset();
        chk("reset_state", 32'(state), 0);
        chk("reset_count", 32'(pulse_count), 0);
        chk("reset_led", 32'(led_shadow), 0);

        // Clean press in MANUAL
        enable = 1'b1;
        tick();
        chk("manual_state", 32'(state), 1);
        btn_raw = 1'b1;
        win_reset();
        repeat (17) tick();
        chk("clean_not_yet", 32'(btn_clean), 0);
        tick();
        chk("clean_at_18", 32'(btn_clean), 1);
        chk("no_pulse_at_18", 32'(toggle_pulse), 0);
        tick();
        chk("pulse_at_19", 32'(toggle_pulse), 1);
        chk("led_after_press", 32'(led_shadow), 1);
        chk("count_after_press", 32'(pulse_count), 1);
        tick();
        chk("pulse_one_cycle", 32'(toggle_pulse), 0);
        repeat (20) tick();
        btn_raw = 1'b0;
        repeat (40) tick();
        chk("release_clean", 32'(btn_clean), 0);
        chk("release_no_pulse", 32'(win_pulses), 1);
        chk("release_count", 32'(pulse_count), 1);

        // Asynchronous reset mid-operation
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_rst_led", 32'(led_shadow), 0);
        chk("async_rst_count", 32'(pulse_count), 0);
        chk("async_rst_state", 32'(state), 0);
        chk("async_rst_tp", 32'(toggle_pulse), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(state), 0);

        // Bounce rejection
        enable   = 1'b1;
        mode_sel = 1'b0;
        tick();
        win_reset();
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            btn_raw = ~btn_raw;
            repeat (5) begin
                tick();
                if (btn_clean) bad = 1'b1;
            end
        end
        chk("bounce_clean_stable", 32'(bad), 0);
        chk("bounce_no_pulse", 32'(win_pulses), 0);
        btn_raw = 1'b1;
        repeat (30) tick();
        chk("bounce_one_pulse", 32'(win_pulses), 1);
        chk("bounce_count", 32'(pulse_count), 1);
        chk("bounce_led", 32'(led_shadow), 1);
        btn_raw = 1'b0;
        repeat (20) tick();

        // Blink
        do_reset();
        enable   = 1'b1;
        mode_sel = 1'b1;
        tick();
        win_reset();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cyc == 20 || cyc == 60 || cyc == 100 || cyc == 140) btn_raw = ~btn_raw;
        end
        chk("blink_state", 32'(state), 2);
        chk("blink_first", 32'(first_pc), 32);
        chk("blink_last", 32'(last_pc), 192);
        chk("blink_pulses", 32'(win_pulses), 6);
        chk("blink_count", 32'(pulse_count), 6);
        chk("blink_led", 32'(led_shadow), 0);

        // BLINK -> MANUAL at bcnt 20, then back
        repeat (12) tick();
        mode_sel = 1'b0;
        tick();
        win_reset();
        repeat (5) tick();
        chk("switch_manual_state", 32'(state), 1);
        chk("switch_manual_nopulse", 32'(win_pulses), 0);
        mode_sel = 1'b1;
        tick();
        win_reset();
        repeat (40) tick();
        chk("reentry_first", 32'(first_pc), 32);
        chk("reentry_pulses", 32'(win_pulses), 1);

        // Enable dropped during a press
        mode_sel = 1'b0;
        tick();
        btn_raw = 1'b1;
        win_reset();
        repeat (10) tick();
        enable = 1'b0;
        repeat (20) tick();
        chk("dis_no_pulse", 32'(win_pulses), 0);
        chk("dis_state", 32'(state), 0);
        chk("dis_clean_runs", 32'(btn_clean), 1);
        enable = 1'b1;
        repeat (5) tick();
        chk("reen_no_pulse", 32'(win_pulses), 0);
        chk("reen_state", 32'(state), 1);
        btn_raw = 1'b0;
        repeat (20) tick();

        // Counter wrap
        do_reset();
        enable   = 1'b1;
        mode_sel = 1'b1;
        tick();
        win_reset();
        repeat (255 * 32) tick();
        chk("wrap_255", 32'(pulse_count), 255);
        chk("wrap_led_odd", 32'(led_shadow), 1);
        repeat (32) tick();
        chk("wrap_zero", 32'(pulse_count), 0);
        chk("wrap_led", 32'(led_shadow), 0);
        chk("wrap_pulses", 32'(win_pulses), 256);

        chk("no_back_to_back", 32'(consec), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
